// File: rtl/axi4_slave_mem.sv
// axi4_slave_mem
//   AXI4 slave memory responder. Independent read and write FSMs each service
//   one outstanding FIXED/INCR/WRAP burst against an internal word-addressed
//   RAM. Out-of-range beats and illegal bursts (reserved burst type, WRAP with
//   a length other than 2/4/8/16 beats) return SLVERR.
//
// Ports
//   aclk, aresetn            clock, synchronous active-low reset
//   aw*  (id/addr/len/burst) write address channel, awready out
//   w*   (data/strb/last)    write data channel, wready out
//   b*   (id/resp)           write response channel, bready in
//   ar*  (id/addr/len/burst) read address channel, arready out
//   r*   (id/data/resp/last) read data channel, rready in
//
// All channel outputs are registered. RAM contents survive reset.

module axi4_slave_mem #(
    parameter int                    DATA_WIDTH = 128,
    parameter int                    ADDR_WIDTH = 40,
    parameter int                    ID_WIDTH   = 4,
    parameter int                    MEM_DEPTH  = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    // write address
    input  logic [ID_WIDTH-1:0]     awid,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic [7:0]              awlen,
    input  logic [1:0]              awburst,
    input  logic                    awvalid,
    output logic                    awready,
    // write data
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wlast,
    input  logic                    wvalid,
    output logic                    wready,
    // write response
    output logic [ID_WIDTH-1:0]     bid,
    output logic [1:0]              bresp,
    output logic                    bvalid,
    input  logic                    bready,
    // read address
    input  logic [ID_WIDTH-1:0]     arid,
    input  logic [ADDR_WIDTH-1:0]   araddr,
    input  logic [7:0]              arlen,
    input  logic [1:0]              arburst,
    input  logic                    arvalid,
    output logic                    arready,
    // read data
    output logic [ID_WIDTH-1:0]     rid,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [1:0]              rresp,
    output logic                    rlast,
    output logic                    rvalid,
    input  logic                    rready
);

    localparam int unsigned BYTES = DATA_WIDTH / 8;
    localparam int          LSB   = $clog2(BYTES);
    localparam int          IDX_W = $clog2(MEM_DEPTH);
    // one bit wider than the address so the upper bound cannot overflow
    localparam logic [ADDR_WIDTH:0] MEM_END =
        {1'b0, BASE_ADDR} + (ADDR_WIDTH+1)'(MEM_DEPTH * BYTES);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // ------------------------------------------------------------------
    // Address helpers
    // ------------------------------------------------------------------
    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        return ({1'b0, a} >= {1'b0, BASE_ADDR}) && ({1'b0, a} < MEM_END);
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
        return IDX_W'((a - BASE_ADDR) >> LSB);
    endfunction

    function automatic logic burst_legal(input logic [7:0] len, input logic [1:0] burst);
        logic ok;
        case (burst)
            2'b00, 2'b01: ok = 1'b1;
            2'b10:        ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
            default:      ok = 1'b0;
        endcase
        return ok;
    endfunction

    // WRAP keeps the bits above the (len+1)*BYTES window and wraps the rest
    function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a,
                                                        input logic [7:0]            len,
                                                        input logic [1:0]            burst);
        logic [ADDR_WIDTH-1:0] inc;
        logic [ADDR_WIDTH-1:0] mask;
        logic [ADDR_WIDTH-1:0] res;
        inc  = a + ADDR_WIDTH'(BYTES);
        mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << LSB) - ADDR_WIDTH'(1);
        case (burst)
            2'b00:   res = a;
            2'b10:   res = (a & ~mask) | (inc & mask);
            default: res = inc;
        endcase
        return res;
    endfunction

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    // ------------------------------------------------------------------
    // Write FSM
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;

    wstate_t               wstate, wstate_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [7:0]            wlen_q, wlen_d;
    logic [1:0]            wburst_q, wburst_d;
    logic [7:0]            wcnt_q, wcnt_d;
    logic                  werr_q, werr_d;
    logic                  awready_d, wready_d, bvalid_d;
    logic [1:0]            bresp_d;
    logic [ID_WIDTH-1:0]   bid_d;
    logic                  w_ok, w_beat_err, mem_we;
    logic [IDX_W-1:0]      w_idx;

    always_comb begin
        wstate_d   = wstate;
        waddr_d    = waddr_q;
        wlen_d     = wlen_q;
        wburst_d   = wburst_q;
        wcnt_d     = wcnt_q;
        werr_d     = werr_q;
        awready_d  = awready;
        wready_d   = wready;
        bvalid_d   = bvalid;
        bresp_d    = bresp;
        bid_d      = bid;
        mem_we     = 1'b0;
        w_idx      = word_idx(waddr_q);
        w_ok       = burst_legal(wlen_q, wburst_q) && in_range(waddr_q);
        // a beat errors if it cannot be stored or if wlast disagrees with the count
        w_beat_err = !w_ok || (wlast != (wcnt_q == wlen_q));

        case (wstate)
            W_IDLE: begin
                awready_d = 1'b1;
                if (awvalid && awready) begin
                    waddr_d   = awaddr;
                    wlen_d    = awlen;
                    wburst_d  = awburst;
                    bid_d     = awid;
                    wcnt_d    = '0;
                    werr_d    = 1'b0;
                    awready_d = 1'b0;
                    wready_d  = 1'b1;
                    wstate_d  = W_DATA;
                end
            end
            W_DATA: begin
                if (wvalid && wready) begin
                    mem_we  = w_ok;
                    werr_d  = werr_q || w_beat_err;
                    waddr_d = next_addr(waddr_q, wlen_q, wburst_q);
                    wcnt_d  = wcnt_q + 8'd1;
                    // beat count, not wlast, terminates the burst
                    if (wcnt_q == wlen_q) begin
                        wready_d = 1'b0;
                        bvalid_d = 1'b1;
                        bresp_d  = (werr_q || w_beat_err) ? RESP_SLVERR : RESP_OKAY;
                        wstate_d = W_RESP;
                    end
                end
            end
            W_RESP: begin
                if (bvalid && bready) begin
                    bvalid_d  = 1'b0;
                    bresp_d   = RESP_OKAY;
                    awready_d = 1'b1;
                    wstate_d  = W_IDLE;
                end
            end
            default: wstate_d = W_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            wstate   <= W_IDLE;
            waddr_q  <= '0;
            wlen_q   <= '0;
            wburst_q <= '0;
            wcnt_q   <= '0;
            werr_q   <= 1'b0;
            awready  <= 1'b0;
            wready   <= 1'b0;
            bvalid   <= 1'b0;
            bresp    <= '0;
            bid      <= '0;
        end else begin
            wstate   <= wstate_d;
            waddr_q  <= waddr_d;
            wlen_q   <= wlen_d;
            wburst_q <= wburst_d;
            wcnt_q   <= wcnt_d;
            werr_q   <= werr_d;
            awready  <= awready_d;
            wready   <= wready_d;
            bvalid   <= bvalid_d;
            bresp    <= bresp_d;
            bid      <= bid_d;
        end
    end

    always_ff @(posedge aclk) begin
        if (aresetn && mem_we) begin
            for (int unsigned b = 0; b < BYTES; b++) begin
                if (wstrb[b]) begin
                    mem[w_idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read FSM
    // ------------------------------------------------------------------
    typedef enum logic {R_IDLE, R_DATA} rstate_t;

    rstate_t               rstate, rstate_d;
    logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
    logic [7:0]            rlen_q, rlen_d;
    logic [1:0]            rburst_q, rburst_d;
    logic [7:0]            rcnt_q, rcnt_d;
    logic                  arready_d, rvalid_d, rlast_d;
    logic [1:0]            rresp_d;
    logic [DATA_WIDTH-1:0] rdata_d;
    logic [ID_WIDTH-1:0]   rid_d;
    logic [ADDR_WIDTH-1:0] r_src_addr;
    logic                  r_ok;
    logic [DATA_WIDTH-1:0] r_word;

    // Source of the beat being loaded into the output register: the AR request
    // when idle, otherwise the beat after the one currently presented. The RAM
    // is read before this edge's write lands, so same-cycle reads see old data.
    always_comb begin
        if (rstate == R_IDLE) begin
            r_src_addr = araddr;
            r_ok       = burst_legal(arlen, arburst) && in_range(araddr);
        end else begin
            r_src_addr = next_addr(raddr_q, rlen_q, rburst_q);
            r_ok       = burst_legal(rlen_q, rburst_q) && in_range(r_src_addr);
        end
        r_word = mem[word_idx(r_src_addr)];
    end

    always_comb begin
        rstate_d  = rstate;
        raddr_d   = raddr_q;
        rlen_d    = rlen_q;
        rburst_d  = rburst_q;
        rcnt_d    = rcnt_q;
        arready_d = arready;
        rvalid_d  = rvalid;
        rlast_d   = rlast;
        rresp_d   = rresp;
        rdata_d   = rdata;
        rid_d     = rid;

        case (rstate)
            R_IDLE: begin
                arready_d = 1'b1;
                if (arvalid && arready) begin
                    raddr_d   = araddr;
                    rlen_d    = arlen;
                    rburst_d  = arburst;
                    rid_d     = arid;
                    rcnt_d    = '0;
                    arready_d = 1'b0;
                    rvalid_d  = 1'b1;
                    rdata_d   = r_ok ? r_word : '0;
                    rresp_d   = r_ok ? RESP_OKAY : RESP_SLVERR;
                    rlast_d   = (arlen == 8'd0);
                    rstate_d  = R_DATA;
                end
            end
            R_DATA: begin
                if (rvalid && rready) begin
                    if (rlast) begin
                        rvalid_d  = 1'b0;
                        rlast_d   = 1'b0;
                        rdata_d   = '0;
                        rresp_d   = RESP_OKAY;
                        arready_d = 1'b1;
                        rstate_d  = R_IDLE;
                    end else begin
                        raddr_d = r_src_addr;
                        rcnt_d  = rcnt_q + 8'd1;
                        rdata_d = r_ok ? r_word : '0;
                        rresp_d = r_ok ? RESP_OKAY : RESP_SLVERR;
                        rlast_d = ((rcnt_q + 8'd1) == rlen_q);
                    end
                end
            end
            default: rstate_d = R_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            rstate   <= R_IDLE;
            raddr_q  <= '0;
            rlen_q   <= '0;
            rburst_q <= '0;
            rcnt_q   <= '0;
            arready  <= 1'b0;
            rvalid   <= 1'b0;
            rlast    <= 1'b0;
            rresp    <= '0;
            rdata    <= '0;
            rid      <= '0;
        end else begin
            rstate   <= rstate_d;
            raddr_q  <= raddr_d;
            rlen_q   <= rlen_d;
            rburst_q <= rburst_d;
            rcnt_q   <= rcnt_d;
            arready  <= arready_d;
            rvalid   <= rvalid_d;
            rlast    <= rlast_d;
            rresp    <= rresp_d;
            rdata    <= rdata_d;
            rid      <= rid_d;
        end
    end

endmodule

// File: tb/tb_axi4_slave_mem.sv
// tb_axi4_slave_mem
//   Directed self-checking bench for axi4_slave_mem (128-bit data, 1024 words,
//   base 0). Inputs change 1 time unit after the rising edge; outputs are
//   sampled at the same point.

module tb_axi4_slave_mem;

    localparam int DW = 128;
    localparam int AW = 40;
    localparam int IW = 4;

    logic          aclk;
    logic          aresetn;
    logic [IW-1:0] awid;
    logic [AW-1:0] awaddr;
    logic [7:0]    awlen;
    logic [1:0]    awburst;
    logic          awvalid;
    logic          awready;
    logic [DW-1:0] wdata;
    logic [15:0]   wstrb;
    logic          wlast;
    logic          wvalid;
    logic          wready;
    logic [IW-1:0] bid;
    logic [1:0]    bresp;
    logic          bvalid;
    logic          bready;
    logic [IW-1:0] arid;
    logic [AW-1:0] araddr;
    logic [7:0]    arlen;
    logic [1:0]    arburst;
    logic          arvalid;
    logic          arready;
    logic [IW-1:0] rid;
    logic [DW-1:0] rdata;
    logic [1:0]    rresp;
    logic          rlast;
    logic          rvalid;
    logic          rready;

    axi4_slave_mem #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .ID_WIDTH  (IW),
        .MEM_DEPTH (1024),
        .BASE_ADDR (40'h0)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
        .rready(rready)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] rd_data [0:255];
    logic [1:0]    rd_resp [0:255];
    logic          rd_last [0:255];
    logic [IW-1:0] rd_id;
    logic [1:0]    resp;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic aw_phase(input logic [AW-1:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input logic [IW-1:0] id);
        awaddr = addr; awlen = len; awburst = burst; awid = id; awvalid = 1'b1;
        for (int k = 0; k < 50 && !awready; k++) tick();
        chk("awready_wait", awready, 1);
        tick();
        awvalid = 1'b0;
        chk("wready_after_aw", wready, 1);
    endtask

    task automatic w_phase(input int len, input logic [DW-1:0] base,
                           input logic [15:0] strb, input int lastbeat);
        for (int i = 0; i <= len; i++) begin
            wvalid = 1'b1; wdata = base + DW'(i); wstrb = strb; wlast = (i == lastbeat);
            for (int k = 0; k < 50 && !wready; k++) tick();
            if (!wready) chk("wready_wait", wready, 1);
            tick();
        end
        wvalid = 1'b0; wlast = 1'b0;
        chk("wready_drop", wready, 0);
    endtask

    task automatic b_phase(input logic [IW-1:0] id, output logic [1:0] r);
        for (int k = 0; k < 50 && !bvalid; k++) tick();
        chk("bvalid_wait", bvalid, 1);
        chk("bid", bid, id);
        r = bresp;
        bready = 1'b1;
        tick();
        bready = 1'b0;
        chk("bvalid_clear", bvalid, 0);
        chk("awready_after_b", awready, 1);
    endtask

    task automatic write_burst(input logic [AW-1:0] addr, input int len, input logic [1:0] burst,
                               input logic [IW-1:0] id, input logic [DW-1:0] base,
                               input logic [15:0] strb, input int lastbeat,
                               output logic [1:0] r);
        aw_phase(addr, 8'(len), burst, id);
        w_phase(len, base, strb, lastbeat);
        b_phase(id, r);
    endtask

    task automatic read_burst(input logic [AW-1:0] addr, input int len, input logic [1:0] burst,
                              input logic [IW-1:0] id);
        araddr = addr; arlen = 8'(len); arburst = burst; arid = id; arvalid = 1'b1;
        for (int k = 0; k < 50 && !arready; k++) tick();
        chk("arready_wait", arready, 1);
        tick();
        arvalid = 1'b0;
        chk("rvalid_at_ar_plus1", rvalid, 1);
        rready = 1'b1;
        for (int i = 0; i <= len; i++) begin
            for (int k = 0; k < 50 && !rvalid; k++) tick();
            if (!rvalid) chk("rvalid_wait", rvalid, 1);
            rd_data[i] = rdata; rd_resp[i] = rresp; rd_last[i] = rlast; rd_id = rid;
            tick();
        end
        rready = 1'b0;
        chk("rvalid_after_last", rvalid, 0);
        chk("arready_after_r", arready, 1);
        chk("rid", rd_id, id);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int beat;
        aresetn = 1'b0;
        awid = '0; awaddr = '0; awlen = '0; awburst = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arburst = '0; arvalid = 1'b0; rready = 1'b0;

        // reset state
        repeat (3) tick();
        chk("rst_awready", awready, 0);
        chk("rst_arready", arready, 0);
        chk("rst_wready", wready, 0);
        chk("rst_bvalid", bvalid, 0);
        chk("rst_rvalid", rvalid, 0);
        aresetn = 1'b1;
        tick();
        chk("rel_awready", awready, 1);
        chk("rel_arready", arready, 1);

        // INCR write words 4..7 = 1..4, read back
        write_burst(40'h40, 3, 2'b01, 4'h3, 128'd1, 16'hFFFF, 3, resp);
        chk("incr_bresp", resp, 2'b00);
        read_burst(40'h40, 3, 2'b01, 4'h5);
        for (int i = 0; i < 4; i++) begin
            chk("incr_rdata", rd_data[i], 128'(i + 1));
            chk("incr_rresp", rd_resp[i], 2'b00);
            chk("incr_rlast", rd_last[i], (i == 3));
        end

        // linear fill words 0..3 = A0..A3, WRAP read from word 3
        write_burst(40'h0, 3, 2'b01, 4'h1, 128'hA0, 16'hFFFF, 3, resp);
        chk("fill_bresp", resp, 2'b00);
        read_burst(40'h30, 3, 2'b10, 4'h2);
        chk("wrap_b0", rd_data[0], 128'hA3);
        chk("wrap_b1", rd_data[1], 128'hA0);
        chk("wrap_b2", rd_data[2], 128'hA1);
        chk("wrap_b3", rd_data[3], 128'hA2);
        chk("wrap_rlast", rd_last[3], 1);
        // WRAP with 3 beats is illegal
        read_burst(40'h30, 2, 2'b10, 4'h2);
        for (int i = 0; i < 3; i++) begin
            chk("wrap3_rresp", rd_resp[i], 2'b10);
            chk("wrap3_rdata", rd_data[i], 128'h0);
        end
        chk("wrap3_rlast", rd_last[2], 1);
        // reserved burst type
        read_burst(40'h0, 0, 2'b11, 4'h6);
        chk("rsvd_rresp", rd_resp[0], 2'b10);
        chk("rsvd_rdata", rd_data[0], 128'h0);

        // partial strobe over all-ones word 5
        write_burst(40'h50, 0, 2'b01, 4'h4, '1, 16'hFFFF, 0, resp);
        write_burst(40'h50, 0, 2'b01, 4'h4, 128'h0123456789ABCDEF_FEDCBA9876543210,
                    16'h000F, 0, resp);
        chk("strb_bresp", resp, 2'b00);
        read_burst(40'h50, 0, 2'b01, 4'h4);
        chk("strb_rdata", rd_data[0], 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_76543210);

        // out-of-range write: SLVERR, no aliasing into word 0
        write_burst(40'h4000, 0, 2'b01, 4'h7, 128'h5555, 16'hFFFF, 0, resp);
        chk("oor_bresp", resp, 2'b10);
        read_burst(40'h0, 0, 2'b01, 4'h0);
        chk("oor_word0", rd_data[0], 128'hA0);
        read_burst(40'h4000, 0, 2'b01, 4'h0);
        chk("oor_rresp", rd_resp[0], 2'b10);
        chk("oor_rdata", rd_data[0], 128'h0);

        // R backpressure: rready alternates 0/1
        araddr = 40'h0; arlen = 8'd3; arburst = 2'b01; arid = 4'h9; arvalid = 1'b1;
        for (int k = 0; k < 50 && !arready; k++) tick();
        chk("bp_arready", arready, 1);
        tick();
        arvalid = 1'b0;
        beat = 0;
        for (int c = 0; c < 40 && beat < 4; c++) begin
            rready = c[0];
            chk("bp_rvalid", rvalid, 1);
            chk("bp_rdata", rdata, 128'hA0 + DW'(beat));
            chk("bp_rlast", rlast, (beat == 3));
            tick();
            if (rready) beat++;
        end
        rready = 1'b0;
        chk("bp_beats", beat, 4);
        chk("bp_rvalid_end", rvalid, 0);

        // B backpressure: bvalid held, competing AW not accepted
        aw_phase(40'h80, 8'd0, 2'b01, 4'h2);
        w_phase(0, 128'h77, 16'hFFFF, 0);
        for (int k = 0; k < 50 && !bvalid; k++) tick();
        awaddr = 40'h90; awlen = 8'd0; awburst = 2'b01; awvalid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            chk("bstall_bvalid", bvalid, 1);
            chk("bstall_awready", awready, 0);
            tick();
        end
        awvalid = 1'b0;
        chk("bstall_bresp", bresp, 2'b00);
        bready = 1'b1;
        tick();
        bready = 1'b0;
        chk("bstall_bvalid_clr", bvalid, 0);
        read_burst(40'h80, 0, 2'b01, 4'h1);
        chk("bstall_rdata", rd_data[0], 128'h77);

        // same-cycle write and read of word 7: read sees old value 4
        aw_phase(40'h70, 8'd0, 2'b01, 4'hA);
        wvalid = 1'b1; wdata = 128'h99; wstrb = 16'hFFFF; wlast = 1'b1;
        araddr = 40'h70; arlen = 8'd0; arburst = 2'b01; arid = 4'hB; arvalid = 1'b1;
        chk("conc_wready", wready, 1);
        chk("conc_arready", arready, 1);
        tick();
        wvalid = 1'b0; wlast = 1'b0; arvalid = 1'b0;
        chk("conc_rvalid", rvalid, 1);
        chk("conc_old_data", rdata, 128'h4);
        rready = 1'b1;
        tick();
        rready = 1'b0;
        b_phase(4'hA, resp);
        chk("conc_bresp", resp, 2'b00);
        read_burst(40'h70, 0, 2'b01, 4'h0);
        chk("conc_new_data", rd_data[0], 128'h99);

        // early wlast: all 4 beats taken and written, SLVERR
        write_burst(40'hC0, 3, 2'b01, 4'h3, 128'h500, 16'hFFFF, 1, resp);
        chk("early_wlast_bresp", resp, 2'b10);
        read_burst(40'hC0, 3, 2'b01, 4'h3);
        for (int i = 0; i < 4; i++) chk("early_wlast_data", rd_data[i], 128'h500 + DW'(i));
        // missing wlast
        write_burst(40'hE0, 1, 2'b01, 4'h3, 128'h600, 16'hFFFF, -1, resp);
        chk("no_wlast_bresp", resp, 2'b10);

        // FIXED write: all beats land on one word, last wins
        write_burst(40'h2000, 2, 2'b00, 4'h8, 128'h30, 16'hFFFF, 2, resp);
        chk("fixed_bresp", resp, 2'b00);
        read_burst(40'h2000, 0, 2'b01, 4'h8);
        chk("fixed_rdata", rd_data[0], 128'h32);

        // 256-beat INCR
        write_burst(40'h1000, 255, 2'b01, 4'hC, 128'h1000, 16'hFFFF, 255, resp);
        chk("len255_bresp", resp, 2'b00);
        read_burst(40'h1000, 255, 2'b01, 4'hC);
        chk("len255_b0", rd_data[0], 128'h1000);
        chk("len255_b128", rd_data[128], 128'h1080);
        chk("len255_b255", rd_data[255], 128'h10FF);
        chk("len255_rlast254", rd_last[254], 0);
        chk("len255_rlast255", rd_last[255], 1);

        // reset in the middle of an 8-beat read
        write_burst(40'h100, 7, 2'b01, 4'h1, 128'h200, 16'hFFFF, 7, resp);
        chk("r8_bresp", resp, 2'b00);
        araddr = 40'h100; arlen = 8'd7; arburst = 2'b01; arid = 4'h1; arvalid = 1'b1;
        for (int k = 0; k < 50 && !arready; k++) tick();
        tick();
        arvalid = 1'b0;
        rready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("r8_pre_rdata", rdata, 128'h200 + DW'(i));
            tick();
        end
        rready = 1'b0;
        chk("r8_pre_rvalid", rvalid, 1);
        aresetn = 1'b0;
        tick();
        chk("r8_rst_rvalid", rvalid, 0);
        chk("r8_rst_arready", arready, 0);
        aresetn = 1'b1;
        tick();
        chk("r8_rel_arready", arready, 1);
        chk("r8_rel_awready", awready, 1);
        read_burst(40'h100, 7, 2'b01, 4'h2);
        for (int i = 0; i < 8; i++) chk("r8_reread", rd_data[i], 128'h200 + DW'(i));
        chk("r8_rlast6", rd_last[6], 0);
        chk("r8_rlast7", rd_last[7], 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
